// File: rtl/pwm_gen_if.sv
// pwm_gen_if: run/duty request in, gate-drive pair, period marker and busy out.
// The generator takes the slave side; the controlling logic takes the master side.
interface pwm_gen_if #(
    parameter int WIDTH = 11
);
    logic             en;
    logic [WIDTH-1:0] duty;
    logic             pwm_high;
    logic             pwm_low;
    logic             pwm_synch;
    logic             busy;

    modport master (
        output en,
        output duty,
        input  pwm_high,
        input  pwm_low,
        input  pwm_synch,
        input  busy
    );

    modport slave (
        input  en,
        input  duty,
        output pwm_high,
        output pwm_low,
        output pwm_synch,
        output busy
    );
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: complementary gate-drive pair from a free-running period counter
// compared against a double-buffered duty value. Disabling lets the current
// period finish with the low side on before both outputs go off.
// Optional build macro PWM_CENTER_ALIGN_EN: up/down counter, pulse centred on
// the valley, shadow load and synch at the valley. Default is edge-aligned.
module pwm_gen #(
    parameter int WIDTH = 11
) (
    input  logic     clk,
    input  logic     rst_n,
    pwm_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] duty_active;
    logic             boundary;    // shadow-load point of the period
    logic             drain_done;  // last counter value of a draining period
    logic             on;

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_down;
    logic dir_next;

    // Triangle count: 0 up to MAX, back down to 0; each end turns the direction
    always_comb begin
        cnt_next = cnt + ONE;
        dir_next = 1'b0;
        if (cnt == '0) begin
            cnt_next = ONE;
            dir_next = 1'b0;
        end else if (cnt == MAX) begin
            cnt_next = MAX - ONE;
            dir_next = 1'b1;
        end else if (dir_down) begin
            cnt_next = cnt - ONE;
            dir_next = 1'b1;
        end
    end

    assign boundary   = (cnt == '0);
    // Valley on the down slope closes the period; the valley of RUN entry does not
    assign drain_done = (cnt == '0) && dir_down;
`else
    assign cnt_next   = cnt + ONE;
    assign boundary   = (cnt == MAX);
    assign drain_done = (cnt == MAX);
`endif

    assign on       = (cnt < duty_active);
    assign bus.busy = (state != IDLE);

    // Control FSM, period counter, duty shadow register and registered drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            duty_active   <= '0;
            bus.pwm_high  <= 1'b0;
            bus.pwm_low   <= 1'b0;
            bus.pwm_synch <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    cnt           <= '0;
                    duty_active   <= bus.duty;
                    bus.pwm_high  <= 1'b0;
                    bus.pwm_low   <= 1'b0;
                    bus.pwm_synch <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                    dir_down      <= 1'b0;
`endif
                    if (bus.en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt_next;
`ifdef PWM_CENTER_ALIGN_EN
                    dir_down <= dir_next;
`endif
                    if (boundary) begin
                        duty_active <= bus.duty;
                    end
                    bus.pwm_high  <= on;
                    bus.pwm_low   <= ~on;
                    bus.pwm_synch <= (cnt == '0);
                    if (!bus.en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    bus.pwm_high  <= 1'b0;
                    bus.pwm_low   <= 1'b1;
                    bus.pwm_synch <= 1'b0;
                    if (drain_done) begin
                        state <= IDLE;
                        cnt   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
                        dir_down <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt_next;
`ifdef PWM_CENTER_ALIGN_EN
                        dir_down <= dir_next;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: table of stimulus segments with hand-counted output totals,
// a hand-written asynchronous-reset sequence, then randomized stimulus, all
// checked cycle by cycle against a period-position reference model.
`timescale 1ns/1ps
module tb_pwm_gen;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int PER  = 2 * MAXV;
    localparam int DR   = 3;
    localparam int RA   = 1;
`else
    localparam int W    = 11;
    localparam int MAXV = (1 << W) - 1;
    localparam int PER  = 1 << W;
    localparam int DR   = 1000;
    localparam int RA   = 701;
`endif

    logic clk = 1'b0;
    logic rst_n;

    pwm_gen_if #(.WIDTH(W)) bus ();

    pwm_gen #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int hi_acc, lo_acc, sy_acc;

    // Reference model: mode (0 idle, 1 run, 2 drain), cycles since RUN entry, latched duty
    int m_st   = 0;
    int m_t    = 0;
    int m_dact = 0;

    // Counter value seen at a given position within the run
    function automatic int cnt_at(input int t);
        int u;
        u = t % PER;
`ifdef PWM_CENTER_ALIGN_EN
        return (u <= MAXV) ? u : (PER - u);
`else
        return u;
`endif
    endfunction

    function automatic bit at_bnd(input int t);
`ifdef PWM_CENTER_ALIGN_EN
        return cnt_at(t) == 0;
`else
        return cnt_at(t) == MAXV;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, bus.pwm_high, bus.pwm_low, bus.pwm_synch, bus.busy};
    endfunction

    task automatic step(input bit e, input int d);
        bit eh, el, es;
        int c;
        bus.en   = e;
        bus.duty = d[W-1:0];
        @(posedge clk);
        eh = 1'b0; el = 1'b0; es = 1'b0;
        case (m_st)
            0: begin
                m_dact = d & MAXV;
                if (e) begin
                    m_st = 1;
                    m_t  = 0;
                end
            end
            1: begin
                c  = cnt_at(m_t);
                eh = (c < m_dact);
                el = !eh;
                es = (c == 0);
                if (at_bnd(m_t)) m_dact = d & MAXV;
                m_t++;
                if (!e) m_st = 2;
            end
            default: begin
                el = 1'b1;
                if (at_bnd(m_t)) m_st = 0;
                else m_t++;
            end
        endcase
        #1;
        check("cycle", outs(), {28'd0, eh, el, es, (m_st != 0)});
        hi_acc += int'(bus.pwm_high);
        lo_acc += int'(bus.pwm_low);
        sy_acc += int'(bus.pwm_synch);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check("async_rst_outputs", outs(), 32'd0);
        m_st = 0; m_t = 0; m_dact = 0;
        #1 rst_n = 1'b1;
    endtask

    function automatic int pick_duty();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return MAXV;
            2: return 1;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    typedef struct {
        bit en;
        int duty;
        int cycles;
        int hi;
        int lo;
        int sy;
        bit busy;
    } seg_t;

    seg_t tbl[$];

    initial begin
`ifdef PWM_CENTER_ALIGN_EN
        tbl.push_back('{1'b0, 3, 3,  0, 0,  0, 1'b0});
        tbl.push_back('{1'b1, 3, 1,  0, 0,  0, 1'b1});
        tbl.push_back('{1'b1, 3, 28, 3, 25, 1, 1'b1});
        tbl.push_back('{1'b1, 3, 5,  5, 0,  1, 1'b1});
        tbl.push_back('{1'b1, 5, 25, 0, 25, 0, 1'b1});
        tbl.push_back('{1'b1, 5, 2,  2, 0,  0, 1'b1});
        tbl.push_back('{1'b0, 5, 1,  1, 0,  1, 1'b1});
        tbl.push_back('{1'b0, 5, 30, 0, 30, 0, 1'b0});
        tbl.push_back('{1'b0, 5, 2,  0, 0,  0, 1'b0});
`else
        tbl.push_back('{1'b0, 100,  3,    0,    0,    0, 1'b0});
        tbl.push_back('{1'b1, 100,  1,    0,    0,    0, 1'b1});
        tbl.push_back('{1'b1, 100,  2048, 100,  1948, 1, 1'b1});
        tbl.push_back('{1'b1, 100,  50,   50,   0,    1, 1'b1});
        tbl.push_back('{1'b1, 1500, 1998, 50,   1948, 0, 1'b1});
        tbl.push_back('{1'b1, 1500, 2048, 1500, 548,  1, 1'b1});
        tbl.push_back('{1'b1, 0,    2048, 1500, 548,  1, 1'b1});
        tbl.push_back('{1'b1, 2047, 2048, 0,    2048, 1, 1'b1});
        tbl.push_back('{1'b1, 1000, 2048, 2047, 1,    1, 1'b1});
        tbl.push_back('{1'b1, 1000, 300,  300,  0,    1, 1'b1});
        tbl.push_back('{1'b0, 1000, 1,    1,    0,    0, 1'b1});
        tbl.push_back('{1'b0, 1000, 100,  0,    100,  0, 1'b1});
        tbl.push_back('{1'b1, 1000, 5,    0,    5,    0, 1'b1});
        tbl.push_back('{1'b0, 1000, 1642, 0,    1642, 0, 1'b0});
        tbl.push_back('{1'b0, 1000, 2,    0,    0,    0, 1'b0});
`endif

        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.duty = '0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", outs(), 32'd0);
        #1 rst_n = 1'b1;

        // Table segments: per-cycle model check plus hand-counted totals
        for (int i = 0; i < tbl.size(); i++) begin
            hi_acc = 0; lo_acc = 0; sy_acc = 0;
            for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].en, tbl[i].duty);
            check($sformatf("seg%0d_high_cycles", i), hi_acc, tbl[i].hi);
            check($sformatf("seg%0d_low_cycles", i), lo_acc, tbl[i].lo);
            check($sformatf("seg%0d_synch_pulses", i), sy_acc, tbl[i].sy);
            check($sformatf("seg%0d_busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
        end

        // Asynchronous reset while the high side is on, then restart
        step(1'b1, DR);
        for (int k = 0; k < RA; k++) step(1'b1, DR);
        check("pre_reset_high", {31'd0, bus.pwm_high}, 32'd1);
        async_reset();
        step(1'b1, DR);
        check("restart_entry", outs(), 32'b0001);
        step(1'b1, DR);
        check("restart_first_synch", outs(), 32'b1011);

        // Randomized segments, some with duty churning every cycle
        for (int s = 0; s < 14; s++) begin
            bit e;
            int d;
            int len;
            int mode;
            e    = ($urandom_range(0, 4) != 0);
            mode = int'($urandom_range(0, 3));
            d    = pick_duty();
            len  = int'($urandom_range(1, PER + PER / 2));
            for (int k = 0; k < len; k++) begin
                if (mode == 0) d = pick_duty();
                step(e, d);
            end
            if ($urandom_range(0, 5) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
